// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: instruction-fetch front end for the RV32I core.
// Issues word-aligned fetch requests over a valid/ready interface, collects the
// in-order responses into a small prefetch FIFO tagged with their PCs, and
// flushes everything on a branch/jump redirect. Requests already in flight
// when a redirect happens are remembered so their responses can be dropped.
module riscv_fetch_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int unsigned       FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [XLEN-1:0]   instr_pc,
  output logic [XLEN-1:0]   instr_pc_plus4,
  output logic              misalign_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam cnt_t            ONE     = cnt_t'(1);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]     fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  cnt_t            count_q, count_d;
  cnt_t            outstanding_q, outstanding_d;
  cnt_t            discard_q, discard_d;
  logic            misalign_q, misalign_d;

  logic [CW:0]     inflight;
  logic [XLEN-1:0] redirect_aligned;
  logic            req_fire;
  logic            rsp_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;

  // Every issued request owns a FIFO slot until it is consumed, so
  // outstanding + buffered never exceeds the FIFO depth.
  assign inflight         = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid   = rst & ~redirect_valid & (inflight < DEPTH_W);
  assign imem_req_addr    = fetch_pc_q;
  assign req_fire         = imem_req_valid & imem_req_ready;

  // A response is thrown away if it belongs to a pre-redirect request, or if
  // a redirect happens in the very cycle it arrives.
  assign rsp_fire         = rst & imem_rsp_valid;
  assign rsp_drop         = rsp_fire & ((discard_q != '0) | redirect_valid);
  assign push             = rsp_fire & ~rsp_drop;

  assign instr_valid      = rst & (count_q != '0);
  assign pop              = instr_valid & instr_ready & ~redirect_valid;
  assign instr_data       = fifo_data_q[rd_ptr_q];
  assign instr_pc         = fifo_pc_q[rd_ptr_q];
  assign instr_pc_plus4   = fifo_pc_q[rd_ptr_q] + FOUR;
  assign misalign_err     = misalign_q;

  assign redirect_aligned = {redirect_target[XLEN-1:2], 2'b00};

  // Next-state for PCs, counters and FIFO pointers; a redirect overrides all.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    discard_d     = discard_q;
    misalign_d    = 1'b0;
    outstanding_d = outstanding_q + (req_fire ? ONE : '0) - (rsp_fire ? ONE : '0);

    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      discard_d  = outstanding_q - (rsp_fire ? ONE : '0);
      misalign_d = (redirect_target[1:0] != 2'b00);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + FOUR;
      end
      if (rsp_drop) begin
        discard_d = discard_q - ONE;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + FOUR;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      misalign_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      misalign_q    <= misalign_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  // Memory must never answer a request that was not issued.
  assert property (@(posedge clk) disable iff (!rst)
                   imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: directed checks of the fetch unit against an in-order
// memory model with programmable latency.
module tb_riscv_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        misalign_err;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pending[$];
  int    checkCount = 0;
  int    errorCount = 0;
  int    cyc        = 0;
  int    memLat     = 1;
  int    accTotal   = 0;
  int    waited;

  riscv_fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_pc_plus4  (instr_pc_plus4),
    .misalign_err    (misalign_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance n cycles; the memory model answers accepted requests in order
  // after memLat cycles. Returns at posedge+2 with inputs settled.
  task automatic applyStimulus(input int n);
    logic        accNow;
    logic [31:0] accAddr;
    pend_t       p;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      accNow  = imem_req_valid && imem_req_ready;
      accAddr = imem_req_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (imem_rsp_valid && pending.size() > 0) void'(pending.pop_front());
      if (accNow) begin
        p.addr = accAddr;
        p.due  = cyc + memLat - 1;
        pending.push_back(p);
        accTotal++;
      end
      if (pending.size() > 0 && pending[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = dataOf(pending[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
      #1;
    end
  endtask

  task automatic holdReset(input int n);
    rst = 1'b0;
    applyStimulus(n);
  endtask

  task automatic releaseReset();
    rst = 1'b1;
    pending.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    accTotal       = 0;
    #1;
  endtask

  task automatic waitInstr(input int maxCycles, output int n);
    n = 0;
    while (!instr_valid && n <= maxCycles) begin
      applyStimulus(1);
      n++;
    end
  endtask

  // Directed test sequence.
  initial begin
    rst             = 1'b0;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    instr_ready     = 1'b1;

    // Reset: outputs quiet, redirects ignored
    applyStimulus(2);
    redirect_valid  = 1'b1;
    redirect_target = 32'h1F2;
    #1;
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1);
    redirect_valid = 1'b0;
    #1;
    checkOutput("rst_misalign", {31'b0, misalign_err}, 32'd0);

    // 1: release, 1-cycle memory, sustained fetch
    memLat = 1;
    releaseReset();
    checkOutput("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t1_addr0", imem_req_addr, 32'h0);
    applyStimulus(1);
    checkOutput("t1_addr1", imem_req_addr, 32'h4);
    checkOutput("t1_valid_c1", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1);
    checkOutput("t1_valid_c2", {31'b0, instr_valid}, 32'd1);
    checkOutput("t1_pc0", instr_pc, 32'h0);
    checkOutput("t1_data0", instr_data, 32'hC0DE0000);
    checkOutput("t1_link0", instr_pc_plus4, 32'h4);
    applyStimulus(1);
    checkOutput("t1_pc1", instr_pc, 32'h4);
    checkOutput("t1_data1", instr_data, 32'hC0DE0004);
    applyStimulus(1);
    checkOutput("t1_pc2", instr_pc, 32'h8);
    checkOutput("t1_data2", instr_data, 32'hC0DE0008);

    // 2: decoder stalled, credit limit of 4
    holdReset(2);
    instr_ready = 1'b0;
    releaseReset();
    applyStimulus(10);
    checkOutput("t2_accepts", accTotal, 32'd4);
    checkOutput("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    applyStimulus(1);
    checkOutput("t2_resume", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("t2_head_pc_next", instr_pc, 32'h4);

    // 3: redirect with three requests in flight
    holdReset(2);
    memLat = 4;
    releaseReset();
    applyStimulus(3);
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    #1;
    checkOutput("t3_no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
    applyStimulus(1);
    redirect_valid = 1'b0;
    #1;
    checkOutput("t3_fetch_target", imem_req_addr, 32'h100);
    waitInstr(12, waited);
    checkOutput("t3_latency", waited, 32'd5);
    checkOutput("t3_pc", instr_pc, 32'h100);
    checkOutput("t3_data", instr_data, 32'hC0DE0100);
    checkOutput("t3_link", instr_pc_plus4, 32'h104);
    applyStimulus(1);
    checkOutput("t3_pc_next", instr_pc, 32'h104);
    checkOutput("t3_data_next", instr_data, 32'hC0DE0104);

    // 4: redirect coinciding with a response and a pop
    holdReset(2);
    memLat = 1;
    releaseReset();
    applyStimulus(4);
    checkOutput("t4_head_before", instr_pc, 32'h8);
    checkOutput("t4_rsp_present", {31'b0, imem_rsp_valid}, 32'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    applyStimulus(1);
    redirect_valid = 1'b0;
    #1;
    checkOutput("t4_flushed", {31'b0, instr_valid}, 32'd0);
    checkOutput("t4_fetch_target", imem_req_addr, 32'h200);
    checkOutput("t4_misalign_clear", {31'b0, misalign_err}, 32'd0);
    applyStimulus(1);
    checkOutput("t4_still_empty", {31'b0, instr_valid}, 32'd0);
    applyStimulus(1);
    checkOutput("t4_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("t4_pc", instr_pc, 32'h200);
    checkOutput("t4_data", instr_data, 32'hC0DE0200);

    // 5: misaligned redirect target
    redirect_valid  = 1'b1;
    redirect_target = 32'h1F2;
    applyStimulus(1);
    redirect_valid = 1'b0;
    #1;
    checkOutput("t5_misalign_pulse", {31'b0, misalign_err}, 32'd1);
    checkOutput("t5_fetch_aligned", imem_req_addr, 32'h1F0);
    applyStimulus(1);
    checkOutput("t5_misalign_drop", {31'b0, misalign_err}, 32'd0);
    applyStimulus(1);
    checkOutput("t5_pc", instr_pc, 32'h1F0);
    checkOutput("t5_data", instr_data, 32'hC0DE01F0);

    // 6: reset mid-stream with two requests outstanding
    holdReset(2);
    memLat = 3;
    releaseReset();
    applyStimulus(2);
    rst = 1'b0;
    #1;
    checkOutput("t6_req_gated", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("t6_instr_gated", {31'b0, instr_valid}, 32'd0);
    applyStimulus(3);
    releaseReset();
    checkOutput("t6_empty_after", {31'b0, instr_valid}, 32'd0);
    checkOutput("t6_refetch_addr", imem_req_addr, 32'h0);
    checkOutput("t6_misalign", {31'b0, misalign_err}, 32'd0);
    waitInstr(10, waited);
    checkOutput("t6_latency", waited, 32'd4);
    checkOutput("t6_pc", instr_pc, 32'h0);
    checkOutput("t6_data", instr_data, 32'hC0DE0000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  // Global timeout guard.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
